// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of the producer handshakes and the register-file write port.
// Signals:
//   alu_valid/alu_addr/alu_data/alu_ready  single-cycle ALU producer
//   mem_valid/mem_addr/mem_data/mem_ready  long-latency producer (FIFO side)
//   enc/addrc/datac                        registered register-file write port
//   busy_mask                              registers with a write still outstanding
//   fifo_count                             long-latency FIFO occupancy
// Modports: master = producers and register-file side, slave = the arbiter.
interface regfile_writeback_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_addr;
    logic [31:0]      alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [4:0]       mem_addr;
    logic [31:0]      mem_data;
    logic             mem_ready;
    logic             enc;
    logic [4:0]       addrc;
    logic [31:0]      datac;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, enc, addrc, datac, busy_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, enc, addrc, datac, busy_mask, fifo_count
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter in front of the single register-file write port.
// The ALU result normally wins the port; long-latency results wait in a FIFO
// and drain when the ALU is idle, or are forced through once they have been
// held off for STARVE_LIMIT consecutive cycles. Writes to r0 are consumed but
// never reach the port. busy_mask lets decode stall on uncommitted registers.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    arbiter side of regfile_writeback_arbiter_if (see interface header)
module regfile_writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                        clock,
    input logic                        reset,
    regfile_writeback_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    function automatic logic [31:0] onehot32(input logic [4:0] addr);
        onehot32 = 32'd1 << addr;
    endfunction

    logic [4:0]       addr_mem_r [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [DEPTH-1:0] slot_valid_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [STV_W-1:0] starve_r;
    logic             enc_r;
    logic [4:0]       addrc_r;
    logic [31:0]      datac_r;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             starve_hit_s;
    logic             alu_ready_s;
    logic             mem_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             alu_take_s;
    logic             win_valid_s;
    logic [4:0]       win_addr_s;
    logic [31:0]      win_data_s;
    logic [STV_W-1:0] starve_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [DEPTH-1:0] slot_valid_next_s;
    logic [31:0]      busy_mask_s;

    // Handshake and arbitration decisions for the current cycle.
    always_comb begin
        fifo_empty_s = (count_r == CNT_W'(0));
        fifo_full_s  = (count_r == CNT_W'(DEPTH));
        starve_hit_s = !fifo_empty_s && (starve_r == STV_W'(STARVE_LIMIT));
        alu_ready_s  = !starve_hit_s;
        // No push-on-full even when a pop frees a slot this cycle.
        mem_ready_s  = !fifo_full_s;
        push_s       = bus.mem_valid && mem_ready_s;
        // Only entries already stored at the start of the cycle can pop.
        pop_s        = !fifo_empty_s && (starve_hit_s || !bus.alu_valid);
        alu_take_s   = bus.alu_valid && alu_ready_s;
    end

    // Select the single write source for this cycle.
    always_comb begin
        win_valid_s = 1'b0;
        win_addr_s  = 5'd0;
        win_data_s  = 32'd0;
        if (pop_s) begin
            win_valid_s = 1'b1;
            win_addr_s  = addr_mem_r[rd_ptr_r];
            win_data_s  = data_mem_r[rd_ptr_r];
        end else if (alu_take_s) begin
            win_valid_s = 1'b1;
            win_addr_s  = bus.alu_addr;
            win_data_s  = bus.alu_data;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next-state values for starve counter, occupancy and slot valid bits.
    always_comb begin
        starve_next_s     = starve_r;
        count_next_s      = count_r;
        slot_valid_next_s = slot_valid_r;
        // Below the limit whenever no pop happens, so the increment cannot overflow.
        if (pop_s) begin
            starve_next_s = STV_W'(0);
        end else if (!fifo_empty_s) begin
            starve_next_s = starve_r + STV_W'(1);
        end else begin
            starve_next_s = STV_W'(0);
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            slot_valid_next_s[rd_ptr_r] = 1'b0;
        end else begin
            slot_valid_next_s = slot_valid_next_s;
        end
        if (push_s) begin
            slot_valid_next_s[wr_ptr_r] = 1'b1;
        end else begin
            slot_valid_next_s = slot_valid_next_s;
        end
    end

    // Registers that are outstanding: queued entries plus the write on the port.
    always_comb begin
        busy_mask_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask_s = busy_mask_s | (slot_valid_r[i] ? onehot32(addr_mem_r[i]) : 32'd0);
        end
        busy_mask_s = busy_mask_s | (enc_r ? onehot32(addrc_r) : 32'd0);
        busy_mask_s[0] = 1'b0;
    end

    // FIFO storage, pointers, occupancy and starve counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            starve_r     <= STV_W'(0);
            slot_valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                addr_mem_r[wr_ptr_r] <= bus.mem_addr;
                data_mem_r[wr_ptr_r] <= bus.mem_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r      <= count_next_s;
            starve_r     <= starve_next_s;
            slot_valid_r <= slot_valid_next_s;
        end
    end

    // Registered write port; r0 winners are consumed without asserting enc.
    always_ff @(posedge clock) begin
        if (reset) begin
            enc_r   <= 1'b0;
            addrc_r <= 5'd0;
            datac_r <= 32'd0;
        end else if (win_valid_s && (win_addr_s != 5'd0)) begin
            enc_r   <= 1'b1;
            addrc_r <= win_addr_s;
            datac_r <= win_data_s;
        end else begin
            enc_r   <= 1'b0;
        end
    end

    assign bus.alu_ready  = alu_ready_s;
    assign bus.mem_ready  = mem_ready_s;
    assign bus.enc        = enc_r;
    assign bus.addrc      = addrc_r;
    assign bus.datac      = datac_r;
    assign bus.busy_mask  = busy_mask_s;
    assign bus.fifo_count = count_r;
endmodule
